// File: rtl/debug_pkg.sv
// Shared types and constants for the MIPS debug unit: FSM states, command bytes
// and the sizes of the PC/register dump.
package debug_pkg;

  localparam int NB_DATA     = 32;
  localparam int NB_REG_ADDR = 5;
  localparam int N_REGS      = 32;
  localparam int NB_WORD_CNT = $clog2(N_REGS + 1);

  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_DUMP  = 8'h44;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] ERR_BYTE  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DUMP_LOAD,
    TX_SEND,
    TX_WAIT,
    ERR
  } state_e;

endpackage

// File: rtl/debug_sequencer_word_serializer.sv
// Holds one 32-bit dump word and presents it a byte at a time, MSB first,
// with a flag marking the final byte of the word.
module word_serializer
  import debug_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [NB_DATA-1:0] load_data_i,
  input  logic               shift_i,
  output logic [7:0]         byte_o,
  output logic               last_byte_o
);

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [1:0]         cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = load_data_i;
      cnt_d   = 2'd0;
    end else if (shift_i) begin
      shift_d = {shift_q[NB_DATA-9:0], 8'h00};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_o      = shift_q[NB_DATA-1 -: 8];
  assign last_byte_o = (cnt_q == 2'd3);

endmodule

// File: rtl/debug_sequencer.sv
// Debug-unit controller: decodes UART command bytes, gates the pipeline halt,
// and streams the PC plus the whole register file back over the UART.
module debug_sequencer
  import debug_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  input  logic                   i_cpu_halted,
  input  logic [NB_DATA-1:0]     i_pc,
  output logic                   o_halt,
  output logic [NB_REG_ADDR-1:0] o_reg_addr,
  input  logic [NB_DATA-1:0]     i_reg_data,
  output logic                   o_busy
);

  localparam logic [NB_WORD_CNT-1:0] LAST_WORD = NB_WORD_CNT'(N_REGS);

  state_e                 state_q, state_d;
  logic                   halt_q, halt_d;
  logic [NB_WORD_CNT-1:0] word_q, word_d;
  logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
  logic                   err_sent_q, err_sent_d;

  logic               ser_load, ser_shift, ser_last;
  logic [NB_DATA-1:0] ser_data;
  logic [7:0]         ser_byte;

  word_serializer u_word_serializer (
    .clk_i       (i_clk),
    .rst_i       (i_reset),
    .load_i      (ser_load),
    .load_data_i (ser_data),
    .shift_i     (ser_shift),
    .byte_o      (ser_byte),
    .last_byte_o (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    halt_d     = halt_q;
    word_d     = word_q;
    reg_addr_d = reg_addr_q;
    err_sent_d = err_sent_q;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    ser_data   = i_pc;

    case (state_q)
      IDLE: begin
        halt_d = 1'b1;
        if (i_rx_valid) begin
          if (i_rx_data == CMD_RUN || i_rx_data == CMD_STEP) begin
            // A finished program must never be released again; just report state.
            if (i_cpu_halted) begin
              state_d = DUMP_LOAD;
            end else begin
              halt_d  = 1'b0;
              state_d = (i_rx_data == CMD_RUN) ? RUN : STEP;
            end
          end else if (i_rx_data == CMD_DUMP) begin
            state_d = DUMP_LOAD;
          end else begin
            err_sent_d = 1'b0;
            state_d    = ERR;
          end
        end
      end

      RUN: begin
        if (i_cpu_halted || (i_rx_valid && i_rx_data == CMD_PAUSE)) begin
          halt_d  = 1'b1;
          state_d = DUMP_LOAD;
        end
      end

      STEP: begin
        halt_d  = 1'b1;
        state_d = DUMP_LOAD;
      end

      // The address for the next word is issued here so the register file has
      // a full cycle before the following DUMP_LOAD samples it.
      DUMP_LOAD: begin
        ser_load   = 1'b1;
        ser_data   = (word_q == '0) ? i_pc : i_reg_data;
        reg_addr_d = word_q[NB_REG_ADDR-1:0];
        state_d    = TX_SEND;
      end

      TX_SEND: begin
        state_d = TX_WAIT;
      end

      TX_WAIT: begin
        if (i_tx_done) begin
          ser_shift = 1'b1;
          if (!ser_last) begin
            state_d = TX_SEND;
          end else if (word_q == LAST_WORD) begin
            word_d  = '0;
            state_d = IDLE;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = DUMP_LOAD;
          end
        end
      end

      ERR: begin
        if (!err_sent_q) begin
          err_sent_d = 1'b1;
        end else if (i_tx_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      halt_q     <= 1'b1;
      word_q     <= '0;
      reg_addr_q <= '0;
      err_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      halt_q     <= halt_d;
      word_q     <= word_d;
      reg_addr_q <= reg_addr_d;
      err_sent_q <= err_sent_d;
    end
  end

  assign o_tx_start = (state_q == TX_SEND) || (state_q == ERR && !err_sent_q);
  assign o_tx_data  = (state_q == ERR) ? ERR_BYTE : ser_byte;
  assign o_halt     = halt_q;
  assign o_reg_addr = reg_addr_q;
  assign o_busy     = (state_q != IDLE);

endmodule
